// File: rtl/bp_cce_mmio_cfg_target_if.sv
// rtl/bp_cce_mmio_cfg_target_if.sv - BedRock config-network types and the command/response bus interface
//
// Package: message/header/local-address structs, LCE/CCE mode enums and the
// cfg device register map shared by the endpoint and its loader.
// Interface ports (master = loader side, slave = cfg endpoint side):
//   cmd / cmd_v / cmd_yumi          command message, valid, consumed this cycle
//   resp / resp_v / resp_ready_and  response message, valid, downstream accepts

package bp_cce_mmio_cfg_target_pkg;

  localparam int dword_width_gp  = 64;
  localparam int paddr_width_gp  = 40;
  localparam int lce_id_width_gp = 8;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_lce_mode_uncached = 3'd0,
    e_lce_mode_normal   = 3'd1,
    e_lce_mode_nonspec  = 3'd2
  } bp_lce_mode_e;

  typedef enum logic {
    e_cce_mode_uncached = 1'b0,
    e_cce_mode_normal   = 1'b1
  } bp_cce_mode_e;

  typedef struct packed {
    logic [lce_id_width_gp-1:0] lce_id;
  } bp_bedrock_cce_mem_payload_s;

  typedef struct packed {
    bp_bedrock_mem_type_e        msg_type;
    logic [3:0]                  subop;
    logic [paddr_width_gp-1:0]   addr;
    logic [2:0]                  size;
    bp_bedrock_cce_mem_payload_s payload;
  } bp_bedrock_cce_mem_header_s;

  typedef struct packed {
    bp_bedrock_cce_mem_header_s header;
    logic [dword_width_gp-1:0]  data;
  } bp_bedrock_cce_mem_msg_s;

  localparam int cce_mem_msg_width_gp = $bits(bp_bedrock_cce_mem_msg_s);

  typedef struct packed {
    logic [8:0]  nonlocal;
    logic [6:0]  cce;
    logic [3:0]  dev;
    logic [19:0] addr;
  } bp_local_addr_s;

  localparam logic [3:0]  cfg_dev_gp                 = 4'd2;
  localparam logic [19:0] cfg_reg_freeze_gp          = 20'h00008;
  localparam logic [19:0] cfg_reg_icache_mode_gp     = 20'h00010;
  localparam logic [19:0] cfg_reg_dcache_mode_gp     = 20'h00018;
  localparam logic [19:0] cfg_reg_cce_mode_gp        = 20'h00020;
  localparam logic [19:0] cfg_reg_hio_mask_gp        = 20'h00028;
  localparam logic [19:0] cfg_mem_cce_ucode_base_gp  = 20'h08000;

endpackage

interface bp_cce_mmio_cfg_target_if;
  import bp_cce_mmio_cfg_target_pkg::*;

  bp_bedrock_cce_mem_msg_s cmd;
  logic                    cmd_v;
  logic                    cmd_yumi;
  bp_bedrock_cce_mem_msg_s resp;
  logic                    resp_v;
  logic                    resp_ready_and;

  modport master (output cmd, output cmd_v, input cmd_yumi,
                  input resp, input resp_v, output resp_ready_and);
  modport slave  (input cmd, input cmd_v, output cmd_yumi,
                  output resp, output resp_v, input resp_ready_and);
endinterface

// File: rtl/bp_cce_mmio_cfg_target.sv
// rtl/bp_cce_mmio_cfg_target.sv - per-tile cfg register endpoint with CCE ucode RAM forwarding
//
// Ports:
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   io (slave)                BedRock uncached command in / response out
//   freeze_o                  core freeze
//   icache_mode_o/dcache_mode_o/cce_mode_o  LCE and CCE modes
//   hio_mask_o                HIO enable mask
//   ucode_v_o/w_o/addr_o/data_o  ucode RAM request (valid in the accept cycle)
//   ucode_data_i              ucode read data, one cycle after a read request
// Optional: define BP_CFG_TARGET_ERR_CNT_EN for a 16-bit saturating unmapped-access
// counter at cfg_reg_hio_mask_gp + 8 (read returns count, write clears).

module bp_cce_mmio_cfg_target
  import bp_cce_mmio_cfg_target_pkg::*;
#(
  parameter int inst_ram_addr_width_p = 8,
  parameter int inst_width_p          = 32,
  parameter int resp_els_p            = 2
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  bp_cce_mmio_cfg_target_if.slave          io,
  output logic                             freeze_o,
  output bp_lce_mode_e                     icache_mode_o,
  output bp_lce_mode_e                     dcache_mode_o,
  output bp_cce_mode_e                     cce_mode_o,
  output logic [dword_width_gp-1:0]        hio_mask_o,
  output logic                             ucode_v_o,
  output logic                             ucode_w_o,
  output logic [inst_ram_addr_width_p-1:0] ucode_addr_o,
  output logic [inst_width_p-1:0]          ucode_data_o,
  input  logic [inst_width_p-1:0]          ucode_data_i
);

  localparam int ptr_w = (resp_els_p > 1) ? $clog2(resp_els_p) : 1;
  localparam int cnt_w = $clog2(resp_els_p + 1);
  localparam logic [cnt_w-1:0] els_c   = cnt_w'(resp_els_p);
  localparam logic [20:0]      uc_span = 21'(8 * (2 ** inst_ram_addr_width_p));

  typedef enum logic {IDLE, UC_RD} state_e;
  state_e state;

  bp_bedrock_cce_mem_msg_s    cmd;
  bp_local_addr_s             laddr;
  bp_bedrock_cce_mem_header_s hdr_r;
  assign cmd   = io.cmd;
  assign laddr = cmd.header.addr;

  logic        is_cfg, is_write, in_window;
  logic [20:0] uc_off;
  assign is_cfg   = (laddr.dev == cfg_dev_gp);
  assign is_write = (cmd.header.msg_type == e_bedrock_mem_uc_wr)
                  || (cmd.header.msg_type == e_bedrock_mem_wr);
  assign uc_off    = {1'b0, laddr.addr} - {1'b0, cfg_mem_cce_ucode_base_gp};
  assign in_window = (laddr.addr >= cfg_mem_cce_ucode_base_gp) && (uc_off < uc_span);

`ifdef BP_CFG_TARGET_ERR_CNT_EN
  localparam logic [19:0] cfg_reg_err_cnt_lp = cfg_reg_hio_mask_gp + 20'd8;
  logic [15:0] err_cnt;
`endif

  // Read mux and address map decode
  logic                      mapped;
  logic [dword_width_gp-1:0] rd_data;
  always_comb begin
    rd_data = '0;
    mapped  = 1'b0;
    if (is_cfg) begin
      if (in_window) begin
        mapped = 1'b1;
      end else begin
        case (laddr.addr)
          cfg_reg_freeze_gp:      begin mapped = 1'b1; rd_data = dword_width_gp'(freeze_o);      end
          cfg_reg_icache_mode_gp: begin mapped = 1'b1; rd_data = dword_width_gp'(icache_mode_o); end
          cfg_reg_dcache_mode_gp: begin mapped = 1'b1; rd_data = dword_width_gp'(dcache_mode_o); end
          cfg_reg_cce_mode_gp:    begin mapped = 1'b1; rd_data = dword_width_gp'(cce_mode_o);    end
          cfg_reg_hio_mask_gp:    begin mapped = 1'b1; rd_data = hio_mask_o;                     end
`ifdef BP_CFG_TARGET_ERR_CNT_EN
          cfg_reg_err_cnt_lp:     begin mapped = 1'b1; rd_data = dword_width_gp'(err_cnt);       end
`endif
          default: ;
        endcase
      end
    end
  end

  // Response FIFO
  bp_bedrock_cce_mem_msg_s mem [resp_els_p];
  logic [ptr_w-1:0] rptr, wptr;
  logic [cnt_w-1:0] count;
  logic push, pop, has_room, uc_hit, uc_rd_accept;
  bp_bedrock_cce_mem_msg_s push_msg;

  assign io.resp   = mem[rptr];
  assign io.resp_v = (count != '0);
  assign pop       = io.resp_v & io.resp_ready_and;
  // A ucode read needs no slot at accept but one next cycle; "count - pop < els"
  // at accept guarantees it, since nothing else pushes during UC_RD.
  assign has_room  = (count < els_c) || pop;
  assign io.cmd_yumi = (state == IDLE) & io.cmd_v & has_room;

  assign uc_hit       = is_cfg & in_window;
  assign uc_rd_accept = io.cmd_yumi & uc_hit & ~is_write;
  assign push         = (io.cmd_yumi & ~uc_rd_accept) | (state == UC_RD);

  always_comb begin
    push_msg = '0;
    if (state == UC_RD) begin
      push_msg.header = hdr_r;
      push_msg.data   = dword_width_gp'(ucode_data_i);
    end else begin
      push_msg.header = cmd.header;
      push_msg.data   = is_write ? '0 : rd_data;
    end
  end

  assign ucode_v_o    = io.cmd_yumi & uc_hit;
  assign ucode_w_o    = ucode_v_o & is_write;
  assign ucode_addr_o = uc_off[inst_ram_addr_width_p+2:3];
  assign ucode_data_o = cmd.data[inst_width_p-1:0];

  function automatic logic [ptr_w-1:0] bump(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(resp_els_p - 1)) ? '0 : p + ptr_w'(1);
  endfunction

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      for (int i = 0; i < resp_els_p; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= push_msg;
        wptr      <= bump(wptr);
      end
      if (pop) rptr <= bump(rptr);
      case ({push, pop})
        2'b10:   count <= count + cnt_w'(1);
        2'b01:   count <= count - cnt_w'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
      hdr_r <= '0;
    end else begin
      case (state)
        IDLE: if (uc_rd_accept) begin
          hdr_r <= cmd.header;
          state <= UC_RD;
        end
        UC_RD:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic wr_reg;
  assign wr_reg = io.cmd_yumi & is_write & is_cfg & ~in_window;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      freeze_o      <= 1'b1;
      icache_mode_o <= e_lce_mode_uncached;
      dcache_mode_o <= e_lce_mode_uncached;
      cce_mode_o    <= e_cce_mode_uncached;
      hio_mask_o    <= '0;
    end else if (wr_reg) begin
      case (laddr.addr)
        cfg_reg_freeze_gp:      freeze_o      <= cmd.data[0];
        cfg_reg_icache_mode_gp: icache_mode_o <= bp_lce_mode_e'(cmd.data[2:0]);
        cfg_reg_dcache_mode_gp: dcache_mode_o <= bp_lce_mode_e'(cmd.data[2:0]);
        cfg_reg_cce_mode_gp:    cce_mode_o    <= bp_cce_mode_e'(cmd.data[0]);
        cfg_reg_hio_mask_gp:    hio_mask_o    <= cmd.data;
        default: ;
      endcase
    end
  end

`ifdef BP_CFG_TARGET_ERR_CNT_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      err_cnt <= '0;
    end else if (wr_reg && (laddr.addr == cfg_reg_err_cnt_lp)) begin
      err_cnt <= '0;
    end else if (io.cmd_yumi && !mapped && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

  logic unused;
  assign unused = ^{laddr.nonlocal, laddr.cce};
`else
  logic unused;
  assign unused = ^{laddr.nonlocal, laddr.cce, mapped};
`endif

endmodule

// File: tb/tb_bp_cce_mmio_cfg_target.sv
// tb/tb_bp_cce_mmio_cfg_target.sv - directed vector bench for the cfg endpoint
module tb_bp_cce_mmio_cfg_target;
  import bp_cce_mmio_cfg_target_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bp_cce_mmio_cfg_target_if io();

  logic         freeze, ucode_v, ucode_w;
  bp_lce_mode_e icache_mode, dcache_mode;
  bp_cce_mode_e cce_mode;
  logic [63:0]  hio_mask;
  logic [7:0]   ucode_addr;
  logic [31:0]  ucode_wdata, ucode_rdata;

  bp_cce_mmio_cfg_target #(.inst_ram_addr_width_p(8), .inst_width_p(32), .resp_els_p(2)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .io(io.slave),
    .freeze_o(freeze), .icache_mode_o(icache_mode), .dcache_mode_o(dcache_mode),
    .cce_mode_o(cce_mode), .hio_mask_o(hio_mask),
    .ucode_v_o(ucode_v), .ucode_w_o(ucode_w), .ucode_addr_o(ucode_addr),
    .ucode_data_o(ucode_wdata), .ucode_data_i(ucode_rdata)
  );

  logic [31:0] uram [256];
  initial begin
    for (int i = 0; i < 256; i++) uram[i] = '0;
    ucode_rdata = '0;
  end
  always @(posedge clk) begin
    if (ucode_v && ucode_w) uram[ucode_addr] <= ucode_wdata;
    if (ucode_v && !ucode_w) ucode_rdata <= uram[ucode_addr];
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bp_bedrock_cce_mem_msg_s mkmsg(input bp_bedrock_mem_type_e t, input logic [3:0] dev,
                                                    input logic [19:0] a, input logic [63:0] d,
                                                    input logic [7:0] lce);
    bp_bedrock_cce_mem_msg_s m;
    m = '0;
    m.header.msg_type       = t;
    m.header.subop          = 4'h5;
    m.header.addr           = {9'b0, 7'b0, dev, a};
    m.header.size           = 3'd3;
    m.header.payload.lce_id = lce;
    m.data                  = d;
    return m;
  endfunction

  typedef struct {
    bp_bedrock_mem_type_e t;
    logic [3:0]  dev;
    logic [19:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_uv;
    logic [7:0]  exp_ua;
    logic [31:0] exp_ud;
    logic        exp_f;
    logic [2:0]  exp_ic;
    logic [2:0]  exp_dc;
    logic        exp_cce;
    logic [63:0] exp_hio;
  } vec_t;

  task automatic send(input bp_bedrock_cce_mem_msg_s m, output logic ok, output logic uv,
                      output logic uw, output logic [7:0] ua, output logic [31:0] ud);
    ok = 1'b0; uv = 1'b0; uw = 1'b0; ua = '0; ud = '0;
    io.cmd = m;
    io.cmd_v = 1'b1;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (io.cmd_yumi) begin
        ok = 1'b1; uv = ucode_v; uw = ucode_w; ua = ucode_addr; ud = ucode_wdata;
      end
      @(posedge clk); #1;
    end
    io.cmd_v = 1'b0;
  endtask

  task automatic get_resp(output bp_bedrock_cce_mem_msg_s r, output logic ok);
    ok = 1'b0; r = '0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (io.resp_v) begin
        r = io.resp; ok = 1'b1;
      end
      @(posedge clk); #1;
    end
  endtask

  localparam logic [3:0] D = 4'd2;
  localparam logic [3:0] X = 4'd3;
  localparam logic [63:0] H = 64'hDEADBEEF_01234567;
`ifdef BP_CFG_TARGET_ERR_CNT_EN
  localparam logic [63:0] err_exp = 64'd2;
`else
  localparam logic [63:0] err_exp = 64'd0;
`endif

  localparam bp_bedrock_mem_type_e W = e_bedrock_mem_uc_wr;
  localparam bp_bedrock_mem_type_e R = e_bedrock_mem_uc_rd;

  vec_t vecs [27];
  bp_bedrock_cce_mem_msg_s m, r, m2;
  logic ok, uv, uw, seen;
  logic [7:0] ua;
  logic [31:0] ud;
  int acc;

  initial begin
    //          type dev addr      wdata                  rdata         uv ua     ud            f  ic dc cce hio
    vecs[0]  = '{W, D, 20'h00008, 64'h0,                 64'h0,        0, 8'h00, 32'h0,        0, 0, 0, 0, 64'h0};
    vecs[1]  = '{R, D, 20'h00008, 64'h0,                 64'h0,        0, 8'h00, 32'h0,        0, 0, 0, 0, 64'h0};
    vecs[2]  = '{W, D, 20'h00010, 64'hFFF1,              64'h0,        0, 8'h00, 32'h0,        0, 1, 0, 0, 64'h0};
    vecs[3]  = '{R, D, 20'h00010, 64'h0,                 64'h1,        0, 8'h00, 32'h0,        0, 1, 0, 0, 64'h0};
    vecs[4]  = '{W, D, 20'h00018, 64'h2,                 64'h0,        0, 8'h00, 32'h0,        0, 1, 2, 0, 64'h0};
    vecs[5]  = '{R, D, 20'h00018, 64'h0,                 64'h2,        0, 8'h00, 32'h0,        0, 1, 2, 0, 64'h0};
    vecs[6]  = '{W, D, 20'h00020, 64'h3,                 64'h0,        0, 8'h00, 32'h0,        0, 1, 2, 1, 64'h0};
    vecs[7]  = '{R, D, 20'h00020, 64'h0,                 64'h1,        0, 8'h00, 32'h0,        0, 1, 2, 1, 64'h0};
    vecs[8]  = '{W, D, 20'h00028, H,                     64'h0,        0, 8'h00, 32'h0,        0, 1, 2, 1, H};
    vecs[9]  = '{R, D, 20'h00028, 64'h0,                 H,            0, 8'h00, 32'h0,        0, 1, 2, 1, H};
    vecs[10] = '{W, D, 20'h00008, 64'h3,                 64'h0,        0, 8'h00, 32'h0,        1, 1, 2, 1, H};
    vecs[11] = '{R, D, 20'h00008, 64'h0,                 64'h1,        0, 8'h00, 32'h0,        1, 1, 2, 1, H};
    vecs[12] = '{W, D, 20'h00008, 64'h2,                 64'h0,        0, 8'h00, 32'h0,        0, 1, 2, 1, H};
    vecs[13] = '{W, D, 20'h08028, 64'hFFFFFFFF_000003AB, 64'h0,        1, 8'h05, 32'h3AB,      0, 1, 2, 1, H};
    vecs[14] = '{R, D, 20'h08028, 64'h0,                 64'h3AB,      1, 8'h05, 32'h0,        0, 1, 2, 1, H};
    vecs[15] = '{W, D, 20'h087F8, 64'h1234,              64'h0,        1, 8'hFF, 32'h1234,     0, 1, 2, 1, H};
    vecs[16] = '{R, D, 20'h087F8, 64'h0,                 64'h1234,     1, 8'hFF, 32'h0,        0, 1, 2, 1, H};
    vecs[17] = '{W, D, 20'h00100, 64'h55,                64'h0,        0, 8'h00, 32'h0,        0, 1, 2, 1, H};
    vecs[18] = '{R, D, 20'h00100, 64'h0,                 64'h0,        0, 8'h00, 32'h0,        0, 1, 2, 1, H};
    vecs[19] = '{R, D, 20'h00030, 64'h0,                 err_exp,      0, 8'h00, 32'h0,        0, 1, 2, 1, H};
    vecs[20] = '{R, D, 20'h08800, 64'h0,                 64'h0,        0, 8'h00, 32'h0,        0, 1, 2, 1, H};
    vecs[21] = '{W, X, 20'h00008, 64'h1,                 64'h0,        0, 8'h00, 32'h0,        0, 1, 2, 1, H};
    vecs[22] = '{R, X, 20'h00028, 64'h0,                 64'h0,        0, 8'h00, 32'h0,        0, 1, 2, 1, H};
    vecs[23] = '{W, D, 20'h00030, 64'hFFFF,              64'h0,        0, 8'h00, 32'h0,        0, 1, 2, 1, H};
    vecs[24] = '{R, D, 20'h00030, 64'h0,                 64'h0,        0, 8'h00, 32'h0,        0, 1, 2, 1, H};
    vecs[25] = '{R, D, 20'h07FF8, 64'h0,                 64'h0,        0, 8'h00, 32'h0,        0, 1, 2, 1, H};
    vecs[26] = '{W, X, 20'h08028, 64'h77,                64'h0,        0, 8'h00, 32'h0,        0, 1, 2, 1, H};

    io.cmd = '0;
    io.cmd_v = 1'b0;
    io.resp_ready_and = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_freeze", freeze, 1);
    chk("rst_icache", icache_mode, e_lce_mode_uncached);
    chk("rst_dcache", dcache_mode, e_lce_mode_uncached);
    chk("rst_cce", cce_mode, e_cce_mode_uncached);
    chk("rst_hio", hio_mask, 0);
    chk("rst_resp_v", io.resp_v, 0);
    chk("rst_yumi", io.cmd_yumi, 0);
    chk("rst_ucode_v", ucode_v, 0);
    @(posedge clk); #1;

    // Table-driven vectors
    for (int i = 0; i < 27; i++) begin
      m = mkmsg(vecs[i].t, vecs[i].dev, vecs[i].addr, vecs[i].wdata, 8'(i + 16));
      send(m, ok, uv, uw, ua, ud);
      chk($sformatf("v%0d_accept", i), ok, 1);
      chk($sformatf("v%0d_ucode_v", i), uv, vecs[i].exp_uv);
      if (vecs[i].exp_uv) begin
        chk($sformatf("v%0d_ucode_w", i), uw, vecs[i].t == W);
        chk($sformatf("v%0d_ucode_addr", i), ua, vecs[i].exp_ua);
        chk($sformatf("v%0d_ucode_data", i), ud, vecs[i].exp_ud);
      end
      get_resp(r, ok);
      chk($sformatf("v%0d_resp_seen", i), ok, 1);
      chk($sformatf("v%0d_resp_hdr", i), r.header, m.header);
      chk($sformatf("v%0d_resp_data", i), r.data, vecs[i].exp_rdata);
      chk($sformatf("v%0d_freeze", i), freeze, vecs[i].exp_f);
      chk($sformatf("v%0d_icache", i), icache_mode, vecs[i].exp_ic);
      chk($sformatf("v%0d_dcache", i), dcache_mode, vecs[i].exp_dc);
      chk($sformatf("v%0d_cce", i), cce_mode, vecs[i].exp_cce);
      chk($sformatf("v%0d_hio", i), hio_mask, vecs[i].exp_hio);
    end

    // Ucode read: no accept while in UC_RD, then response with ucode data
    m  = mkmsg(R, D, 20'h08028, 64'h0, 8'd40);
    m2 = mkmsg(R, D, 20'h00008, 64'h0, 8'd41);
    io.cmd = m; io.cmd_v = 1'b1;
    @(negedge clk);
    chk("ucrd_accept", io.cmd_yumi, 1);
    @(posedge clk); #1;
    io.cmd = m2;
    @(negedge clk);
    chk("ucrd_no_accept", io.cmd_yumi, 0);
    chk("ucrd_no_resp_yet", io.resp_v, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ucrd_resp_v", io.resp_v, 1);
    chk("ucrd_resp_data", io.resp.data, 64'h3AB);
    chk("ucrd_resp_hdr", io.resp.header, m.header);
    chk("ucrd_next_accept", io.cmd_yumi, 1);
    @(posedge clk); #1;
    io.cmd_v = 1'b0;
    get_resp(r, ok);
    chk("ucrd_follow_seen", ok, 1);
    chk("ucrd_follow_lce", r.header.payload.lce_id, 41);
    chk("ucrd_follow_data", r.data, 0);

    // Backpressure: two slots fill, third waits for ready
    io.resp_ready_and = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      io.cmd = mkmsg(W, D, 20'h00028, 64'(acc + 1), 8'(acc + 1));
      io.cmd_v = 1'b1;
      @(negedge clk);
      if (io.cmd_yumi) acc++;
      @(posedge clk); #1;
    end
    chk("bp_accepted", acc, 2);
    io.cmd = mkmsg(W, D, 20'h00028, 64'd3, 8'd3);
    io.resp_ready_and = 1'b1;
    @(negedge clk);
    chk("bp_third_accept", io.cmd_yumi, 1);
    chk("bp_first_lce", io.resp.header.payload.lce_id, 1);
    @(posedge clk); #1;
    io.cmd_v = 1'b0;
    for (int k = 2; k <= 3; k++) begin
      get_resp(r, ok);
      chk($sformatf("bp_resp%0d_seen", k), ok, 1);
      chk($sformatf("bp_resp%0d_lce", k), r.header.payload.lce_id, k);
      chk($sformatf("bp_resp%0d_data", k), r.data, 0);
    end
    chk("bp_hio", hio_mask, 3);

    // Asynchronous reset with a buffered response and a pending ucode read
    io.resp_ready_and = 1'b0;
    send(mkmsg(W, D, 20'h00028, 64'h9, 8'd50), ok, uv, uw, ua, ud);
    chk("ar_wr_accept", ok, 1);
    send(mkmsg(R, D, 20'h08028, 64'h0, 8'd51), ok, uv, uw, ua, ud);
    chk("ar_ucrd_accept", ok, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_resp_v", io.resp_v, 0);
    chk("ar_freeze", freeze, 1);
    chk("ar_hio", hio_mask, 0);
    chk("ar_icache", icache_mode, e_lce_mode_uncached);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    io.resp_ready_and = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (io.resp_v) seen = 1'b1;
    end
    chk("ar_no_stale_resp", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
